// File: rtl/dna_pkg.sv
// Shared types and constants for the DNA k-mer matcher.
//   BASE_A/C/G/T : 2-bit base encodings
//   base_t       : one encoded base
//   state_t      : matcher FSM states
//   DEB_CYC      : cycles a synchronised button level must hold to be accepted
package dna_pkg;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'b00;
  localparam base_t BASE_C = 2'b01;
  localparam base_t BASE_G = 2'b10;
  localparam base_t BASE_T = 2'b11;

  localparam int unsigned DEB_CYC = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dna_kmer_matcher_step_pulse_gen.sv
// Button conditioner: 2-FF synchroniser, debounce, rising-edge pulse.
//   clk        : system clock
//   reset      : synchronous, active-low
//   button     : raw asynchronous push button
//   step_pulse : one-cycle pulse per debounced rising edge
module step_pulse_gen
  import dna_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic step_pulse
);

  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_lvl;
  logic [DEB_W-1:0] deb_cnt;

  // Count consecutive cycles the synchronised level differs from the
  // accepted level; any bounce back restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      stable_lvl <= 1'b0;
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync_q1    <= button;
      sync_q2    <= sync_q1;
      step_pulse <= 1'b0;
      if (sync_q2 == stable_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
        stable_lvl <= sync_q2;
        deb_cnt    <= '0;
        step_pulse <= sync_q2;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/dna_kmer_matcher.sv
// Streaming k-mer matcher: loads a K-base query, slides a K-base window over
// REF_LEN reference bases and reports windows with at most MAX_MM mismatches.
// Optional feature macro: BEST_HIT_EN (adds best_pos/best_mm outputs).
//   clk, reset          : clock, synchronous active-low reset
//   start               : begin query load (IDLE only)
//   step_mode, button   : single-step scan gated by debounced button
//   q_valid, q_base     : query base input (LOAD only)
//   ref_valid, ref_base : reference base input, taken when ref_ready
//   ref_ready           : reference base accepted this cycle
//   hit_valid/pos/mm    : registered hit report
//   busy, done          : outside IDLE / scan-end pulse
//   best_pos, best_mm   : best window of the last scan (BEST_HIT_EN)
module dna_kmer_matcher
  import dna_pkg::*;
#(
  parameter int unsigned K       = 8,
  parameter int unsigned REF_LEN = 64,
  parameter int unsigned MAX_MM  = 1,
  parameter int unsigned POS_W   = $clog2(REF_LEN),
  parameter int unsigned MM_W    = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             button,
  input  logic             q_valid,
  input  logic [1:0]       q_base,
  input  logic             ref_valid,
  input  logic [1:0]       ref_base,
  output logic             ref_ready,
  output logic             hit_valid,
  output logic [POS_W-1:0] hit_pos,
  output logic [MM_W-1:0]  hit_mm,
`ifdef BEST_HIT_EN
  output logic [POS_W-1:0] best_pos,
  output logic [MM_W-1:0]  best_mm,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W  = $clog2(REF_LEN + 1);
  localparam int unsigned LCNT_W = $clog2(K);
  localparam int unsigned SEQ_W  = 2 * K;

  state_t             state, state_next;
  logic [SEQ_W-1:0]   query, query_next;
  logic [SEQ_W-1:0]   window, window_next;
  logic [LCNT_W-1:0]  load_cnt, load_cnt_next;
  logic [CNT_W-1:0]   acc_cnt, acc_cnt_next;
  logic               step_pulse;
  logic               win_eval;
  logic [MM_W-1:0]    mm_c;
  logic [POS_W-1:0]   hit_pos_c;
  logic               hit_c;
  logic               ref_ready_next;

  step_pulse_gen u_step (
    .clk        (clk),
    .reset      (reset),
    .button     (button),
    .step_pulse (step_pulse)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      query     <= '0;
      window    <= '0;
      load_cnt  <= '0;
      acc_cnt   <= '0;
      ref_ready <= 1'b0;
      hit_valid <= 1'b0;
      hit_pos   <= '0;
      hit_mm    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      query     <= query_next;
      window    <= window_next;
      load_cnt  <= load_cnt_next;
      acc_cnt   <= acc_cnt_next;
      ref_ready <= ref_ready_next;
      hit_valid <= hit_c;
      if (hit_c) begin
        hit_pos <= hit_pos_c;
        hit_mm  <= mm_c;
      end
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
    end
  end

  // Next-state and datapath update. Newest base enters at the top slot so
  // that after K shifts slot 0 holds the oldest (first) base.
  always_comb begin
    state_next    = state;
    query_next    = query;
    window_next   = window;
    load_cnt_next = load_cnt;
    acc_cnt_next  = acc_cnt;
    win_eval      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next    = LOAD;
          query_next    = '0;
          window_next   = '0;
          load_cnt_next = '0;
          acc_cnt_next  = '0;
        end
      end
      LOAD: begin
        if (q_valid) begin
          query_next = {q_base, query[SEQ_W-1:2]};
          if (load_cnt == LCNT_W'(K - 1)) begin
            state_next    = SCAN;
            load_cnt_next = '0;
          end else begin
            load_cnt_next = load_cnt + LCNT_W'(1);
          end
        end
      end
      SCAN: begin
        if (ref_valid && ref_ready) begin
          window_next  = {ref_base, window[SEQ_W-1:2]};
          acc_cnt_next = acc_cnt + CNT_W'(1);
          win_eval     = (acc_cnt_next >= CNT_W'(K));
          if (acc_cnt_next == CNT_W'(REF_LEN)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Mismatch count of the window as it will stand after this edge.
    mm_c = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (window_next[2*i +: 2] != query[2*i +: 2]) begin
        mm_c = mm_c + MM_W'(1);
      end
    end
    hit_pos_c = POS_W'(acc_cnt_next - CNT_W'(K));
    hit_c     = win_eval && (mm_c <= MM_W'(MAX_MM));

    // Ready is registered: decided from the state we are moving into.
    ref_ready_next = (state_next == SCAN) && (step_mode ? step_pulse : 1'b1);
  end

`ifdef BEST_HIT_EN
  logic best_seen;

  // Lowest mismatch wins; strict compare keeps the earliest on a tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      best_seen <= 1'b0;
      best_pos  <= '0;
      best_mm   <= '0;
    end else if (state == IDLE && start) begin
      best_seen <= 1'b0;
    end else if (win_eval && (!best_seen || mm_c < best_mm)) begin
      best_seen <= 1'b1;
      best_pos  <= hit_pos_c;
      best_mm   <= mm_c;
    end
  end
`endif

endmodule

// File: tb/tb_dna_kmer_matcher.sv
// Scoreboard bench for dna_kmer_matcher with K=4, REF_LEN=8, MAX_MM=1.
module tb_dna_kmer_matcher;

  localparam int unsigned K       = 4;
  localparam int unsigned REF_LEN = 8;
  localparam int unsigned MAX_MM  = 1;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned MM_W    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             step_mode;
  logic             button;
  logic             q_valid;
  logic [1:0]       q_base;
  logic             ref_valid;
  logic [1:0]       ref_base;
  logic             ref_ready;
  logic             hit_valid;
  logic [POS_W-1:0] hit_pos;
  logic [MM_W-1:0]  hit_mm;
  logic             busy;
  logic             done;
`ifdef BEST_HIT_EN
  logic [POS_W-1:0] best_pos;
  logic [MM_W-1:0]  best_mm;
`endif

  dna_kmer_matcher #(
    .K(K), .REF_LEN(REF_LEN), .MAX_MM(MAX_MM), .POS_W(POS_W), .MM_W(MM_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step_mode (step_mode),
    .button    (button),
    .q_valid   (q_valid),
    .q_base    (q_base),
    .ref_valid (ref_valid),
    .ref_base  (ref_base),
    .ref_ready (ref_ready),
    .hit_valid (hit_valid),
    .hit_pos   (hit_pos),
    .hit_mm    (hit_mm),
`ifdef BEST_HIT_EN
    .best_pos  (best_pos),
    .best_mm   (best_mm),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int pos;
    int mm;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   scan_acc = 0;
  int   tot_acc  = 0;
  int   tot_rdy  = 0;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [1:0] enc(byte c);
    case (c)
      "A":     return 2'b00;
      "C":     return 2'b01;
      "G":     return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic void push_hit(int pos, int mm);
    exp_t e;
    e.is_done = 1'b0; e.pos = pos; e.mm = mm;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(int bpos, int bmm);
    exp_t e;
    e.is_done = 1'b1; e.pos = bpos; e.mm = bmm;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard whenever the DUT reports a hit or done.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      scan_acc = 0;
    end else begin
      if (ref_ready) tot_rdy++;
      if (ref_valid && ref_ready) begin
        scan_acc++;
        tot_acc++;
        last_acc = cyc;
      end
      if (hit_valid) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          check("unexpected_hit_pos", int'(hit_pos), -1);
        end else begin
          e = exp_q.pop_front();
          check("hit_pos", int'(hit_pos), e.pos);
          check("hit_mm", int'(hit_mm), e.mm);
        end
      end
      if (done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_latency", cyc - last_acc, 1);
          check("scan_accepts", scan_acc, REF_LEN);
`ifdef BEST_HIT_EN
          check("best_pos", int'(best_pos), e.pos);
          check("best_mm", int'(best_mm), e.mm);
`endif
        end
        scan_acc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_query(input string q);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < q.len(); i++) begin
      q_valid = 1'b1;
      q_base  = enc(q[i]);
      tick();
    end
    q_valid = 1'b0;
  endtask

  // Feeds r[lo..hi-1]; noisy inserts a stall cycle with stray start/q_valid.
  task automatic feed(input string r, input int lo, input int hi, input bit noisy);
    int n;
    for (int i = lo; i < hi; i++) begin
      if (noisy && (i % 2 == 1)) begin
        ref_valid = 1'b0;
        start     = 1'b1;
        q_valid   = 1'b1;
        q_base    = 2'b11;
        tick();
        start   = 1'b0;
        q_valid = 1'b0;
        tick();
      end
      ref_valid = 1'b1;
      ref_base  = enc(r[i]);
      n = 0;
      @(negedge clk);
      while (!ref_ready && n < 64) begin
        n++;
        @(negedge clk);
      end
      if (!ref_ready) begin
        check("ref_ready_timeout", 0, 1);
        ref_valid = 1'b0;
        return;
      end
      tick();
      ref_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("idle_timeout", int'(busy), 0);
    tick();
  endtask

  task automatic press();
    for (int i = 0; i < 5; i++) begin
      button = (i % 2 == 0);
      tick();
    end
    button = 1'b1;
    repeat (40) tick();
    for (int i = 0; i < 5; i++) begin
      button = (i % 2 == 1);
      tick();
    end
    button = 1'b0;
    repeat (40) tick();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ref_ready"}, int'(ref_ready), 0);
    check({tag, "_hit_valid"}, int'(hit_valid), 0);
    check({tag, "_hit_pos"}, int'(hit_pos), 0);
    check({tag, "_hit_mm"}, int'(hit_mm), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
`ifdef BEST_HIT_EN
    check({tag, "_best_pos"}, int'(best_pos), 0);
    check({tag, "_best_mm"}, int'(best_mm), 0);
`endif
  endtask

  initial begin
    int a0, r0;
    reset = 1'b0; start = 1'b0; step_mode = 1'b0; button = 1'b0;
    q_valid = 1'b0; q_base = 2'b00; ref_valid = 1'b0; ref_base = 2'b00;
    repeat (3) tick();
    check_cleared("reset");
    reset = 1'b1;
    tick();

    // Single exact hit in the middle.
    load_query("ACGT");
    check("busy_in_scan", int'(busy), 1);
    push_hit(2, 0);
    push_done(2, 0);
    feed("TTACGTTT", 0, 8, 1'b0);
    wait_idle();

    // Near hit at the first window, exact hit at the last.
    load_query("ACGT");
    push_hit(0, 1);
    push_hit(4, 0);
    push_done(4, 0);
    feed("ACGAACGT", 0, 8, 1'b0);
    wait_idle();

    // Stalls plus stray start/q_valid during the scan.
    load_query("ACGT");
    push_hit(2, 0);
    push_done(2, 0);
    feed("TTACGTTT", 0, 8, 1'b1);
    wait_idle();

    // Button-stepped scan for the first three bases, then free-running.
    step_mode = 1'b1;
    load_query("ACGT");
    push_hit(3, 0);
    push_done(3, 0);
    a0 = tot_acc;
    r0 = tot_rdy;
    ref_valid = 1'b1;
    ref_base  = enc("T");
    repeat (3) press();
    ref_valid = 1'b0;
    check("step_accepts", tot_acc - a0, 3);
    check("step_ready_cycles", tot_rdy - r0, 3);
    step_mode = 1'b0;
    feed("TTTACGTT", 3, 8, 1'b0);
    wait_idle();

    // Reset after five accepts aborts, then a fresh scan runs normally.
    load_query("ACGT");
    feed("TTACGTTT", 0, 5, 1'b0);
    reset = 1'b0;
    tick();
    check_cleared("abort");
    reset = 1'b1;
    tick();
    load_query("ACGT");
    push_hit(0, 1);
    push_hit(4, 0);
    push_done(4, 0);
    feed("ACGAACGT", 0, 8, 1'b0);
    wait_idle();

    // Tie on mismatch count: earliest window is the best.
    load_query("ACGT");
    push_hit(0, 1);
    push_hit(4, 1);
    push_done(0, 1);
    feed("AAGTACGA", 0, 8, 1'b0);
    wait_idle();

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
